// File: rtl/result_drain_fifo_if.sv
// Producer strobe and consumer handshake bundle for result_drain_fifo.
// Status flags and overflow clear also travel on this interface.
interface result_drain_fifo_if #(
  parameter int N  = 32,
  parameter int AW = 2
);
  logic          enable;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          b_valid;
  logic          b_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          clr_ovf;

  modport master (
    output enable, a, b_ready, clr_ovf,
    input  b, b_valid, count, full, empty, overflow
  );

  modport slave (
    input  enable, a, b_ready, clr_ovf,
    output b, b_valid, count, full, empty, overflow
  );
endinterface

// File: rtl/result_drain_fifo.sv
// Captures strobed FP results into a circular buffer and drains
// them in order over valid/ready, flagging words lost when full.
module result_drain_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic               clk,
  input logic               rst,
  result_drain_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic [N-1:0]  head;
  logic          ovf;
  logic          is_full;
  logic          pop;
  logic          push;
  logic          drop;

  assign is_full = (cnt == FULL_CNT);
  assign pop     = (cnt != '0) & bus.b_ready;
  assign push    = bus.enable & (~is_full | pop);
  assign drop    = bus.enable & is_full & ~pop;
  assign rd_nxt  = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.a;
  end

  // Head is registered so it resets to 0 and holds its value once drained;
  // a word landing in the new head slot this edge bypasses the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      cnt    <= cnt_nxt;
      if (cnt_nxt != '0) begin
        if (push && wr_ptr == rd_nxt) head <= bus.a;
        else                          head <= mem[rd_nxt];
      end
      if (drop)             ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

  assign bus.b        = head;
  assign bus.b_valid  = (cnt != '0);
  assign bus.count    = cnt;
  assign bus.full     = is_full;
  assign bus.empty    = (cnt == '0);
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_result_drain_fifo.sv
// Directed bench for result_drain_fifo with a queue scoreboard;
// a negedge monitor checks every completed pop against the queue.
module tb_result_drain_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] sb [$];

  result_drain_fifo_if #(.N(32), .AW(2)) f ();

  result_drain_fifo #(.N(32), .DEPTH(4), .AW(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && f.b_valid && f.b_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got %h expected none", f.b);
      end else begin
        chk("pop_data", f.b, sb.pop_front());
      end
    end
  end

  task automatic cyc(input bit en, input logic [31:0] d,
                     input bit rdy, input bit clr);
    f.enable  = en;
    f.a       = d;
    f.b_ready = rdy;
    f.clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    sb.push_back(d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    f.enable  = 1'b0;
    f.a       = '0;
    f.b_ready = 1'b0;
    f.clr_ovf = 1'b0;
    #2;
    chk("rst_b", f.b, 32'h0);
    chk("rst_valid", 32'(f.b_valid), 32'd0);
    chk("rst_count", 32'(f.count), 32'd0);
    chk("rst_full", 32'(f.full), 32'd0);
    chk("rst_empty", 32'(f.empty), 32'd1);
    chk("rst_ovf", 32'(f.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1 single word
    wr(32'h3F800000);
    chk("t1_valid", 32'(f.b_valid), 32'd1);
    chk("t1_b", f.b, 32'h3F800000);
    chk("t1_count", 32'(f.count), 32'd1);
    drain(1);
    chk("t1_empty", 32'(f.empty), 32'd1);

    // T2 fill and overflow
    for (int i = 1; i <= 4; i++) wr(32'(i));
    cyc(1'b1, 32'd5, 1'b0, 1'b0);
    chk("t2_full", 32'(f.full), 32'd1);
    chk("t2_count", 32'(f.count), 32'd4);
    chk("t2_ovf", 32'(f.overflow), 32'd1);
    drain(4);
    chk("t2_empty", 32'(f.empty), 32'd1);
    chk("t2_ovf_sticky", 32'(f.overflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t2_clr", 32'(f.overflow), 32'd0);

    // T3 full plus simultaneous pop and write
    for (int i = 1; i <= 4; i++) wr(32'(i));
    sb.push_back(32'd9);
    cyc(1'b1, 32'd9, 1'b1, 1'b0);
    chk("t3_count", 32'(f.count), 32'd4);
    chk("t3_ovf", 32'(f.overflow), 32'd0);
    chk("t3_head", f.b, 32'd2);
    // drop and clear on the same edge: set wins
    cyc(1'b1, 32'd77, 1'b0, 1'b1);
    chk("t3_set_wins", 32'(f.overflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_clr", 32'(f.overflow), 32'd0);
    drain(4);
    chk("t3_empty", 32'(f.empty), 32'd1);

    // T4 streaming wrap-around
    for (int i = 0; i < 20; i++) begin
      sb.push_back(32'(i));
      cyc(1'b1, 32'(i), 1'b1, 1'b0);
      chk("t4_count", 32'(f.count), 32'd1);
      chk("t4_head", f.b, 32'(i));
    end
    drain(1);
    chk("t4_empty", 32'(f.empty), 32'd1);

    // T5 backpressure
    wr(32'hA);
    wr(32'hB);
    wr(32'hC);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5_c1", 32'(f.count), 32'd2);
    chk("t5_b1", f.b, 32'hB);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t5_c2", 32'(f.count), 32'd2);
    chk("t5_b2", f.b, 32'hB);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t5_c3", 32'(f.count), 32'd2);
    chk("t5_b3", f.b, 32'hB);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5_c4", 32'(f.count), 32'd1);
    chk("t5_b4", f.b, 32'hC);
    drain(1);

    // T6 asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i));
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    f.b_ready = 1'b0;
    chk("t6_pre_count", 32'(f.count), 32'd3);
    chk("t6_pre_ovf", 32'(f.overflow), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("t6_valid", 32'(f.b_valid), 32'd0);
    chk("t6_count", 32'(f.count), 32'd0);
    chk("t6_empty", 32'(f.empty), 32'd1);
    chk("t6_ovf", 32'(f.overflow), 32'd0);
    chk("t6_b", f.b, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wr(32'h55);
    chk("t6_new_b", f.b, 32'h55);
    chk("t6_new_count", 32'(f.count), 32'd1);
    drain(1);
    chk("t6_end_empty", 32'(f.empty), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
